leta_decoder: RTL and testbench
===============================

LETA_DECODER -- requirements
Module: leta_decoder

Interface
REQ-001 Parameter NCHAN, default 4: number of quadrature channels (trackball 1 X/Y, trackball 2 X/Y).
REQ-002 Parameter CNT_W, default 8: counter and data bus width.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 QA  input  NCHAN  quadrature phase A per channel; asynchronous to clk.
REQ-006 QB  input  NCHAN  quadrature phase B per channel; asynchronous to clk.
REQ-007 CS_b  input  1  chip select, active low (driven by RLETA_b).
REQ-008 AD  input  2  channel select for reads.
REQ-009 TEST  input  1  test mode; 1 = all counters free-run.
REQ-010 RESOLN  input  1  resolution; 0 = x4 (every edge), 1 = x1 (one count per full cycle).
REQ-011 DB  output(tri)  CNT_W  read data; high-Z whenever CS_b = 1.
REQ-012 QERR  output  NCHAN  sticky illegal-transition flag per channel.

Function
REQ-013 Each QA/QB bit SHALL pass through a 2-flop synchronizer; decode uses the second-stage value only.
REQ-014 Each channel SHALL hold prev state {A,B}; the Gray sequence 00->01->11->10->00 is forward (+1); the reverse sequence is backward (-1).
REQ-015 x4 mode: every legal single-bit step SHALL change the count by +/-1 in the cycle after the synchronized change.
REQ-016 x1 mode: only 10->00 SHALL count +1 and only 00->10 SHALL count -1; all other legal steps update prev only.
REQ-017 Two-bit change (00<->11, 01<->10): no count; QERR[ch] set to 1; prev updated.
REQ-018 No change: no count.
REQ-019 Counters SHALL be CNT_W-bit two's-complement and wrap: 0xFF+1 = 0x00; 0x00-1 = 0xFF.
REQ-020 TEST = 1: every counter SHALL increment by 1 each clk; quadrature inputs are ignored; prev keeps tracking.
REQ-021 First sample after reset SHALL only load prev (valid flag per channel) and SHALL NOT count.
REQ-022 CS_b SHALL be synchronized (2 flops); the synchronized falling edge SHALL snapshot counter[AD] into a read latch.
REQ-023 A count and a snapshot in the same cycle: the latch SHALL take the pre-update value; the counter still updates.
REQ-024 DB SHALL drive the read latch while raw CS_b = 0, and is high-Z otherwise (combinational enable).
REQ-025 Reads SHALL NOT clear counters or QERR; counters are absolute positions.
REQ-026 QERR[ch] SHALL clear on a snapshot of channel ch, i.e. a read of ch; a same-cycle new error keeps it set.
REQ-027 AD changes while CS_b stays low SHALL NOT re-snapshot; a new falling edge is required.

Reset
REQ-028 rst_b = 0 SHALL asynchronously clear counters, synchronizers, prev, valid flags, read latch and QERR to 0.
REQ-029 DB SHALL follow REQ-024 during reset (drives 0x00 if CS_b = 0).
REQ-030 Release of rst_b mid-read: no snapshot until the next synchronized CS_b falling edge.

Structure
REQ-031 Package leta_pkg SHALL hold NCHAN, CNT_W, the 2-bit quad state typedef and the step enum {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR}.
REQ-032 Sub-module quad_channel (synchronizer, prev, decode, counter, QERR) SHALL be instantiated NCHAN times; leta_decoder holds the CS_b sync, snapshot and DB driver.

Verification
REQ-033 Reset, then 5 forward x4 cycles on ch0 (20 steps), read AD=0 -> DB = 0x14; other channels read 0x00.
REQ-034 RESOLN=1, 3 reverse cycles on ch2 from 0 -> read AD=2 gives 0xFD.
REQ-035 ch1 preset to 0xFF, one forward x4 step -> 0x00 (wrap); from 0x00, one reverse step -> 0xFF.
REQ-036 ch3 jump 00->11 -> QERR[3] = 1, count unchanged; read AD=3 -> QERR[3] = 0.
REQ-037 TEST=1 for 10 clk from reset -> all four channels read 0x0A (+/-1 per the snapshot cycle, checked against the model).
REQ-038 Forward step synchronized in the same cycle as the CS_b edge on ch0 at 0x07 -> DB = 0x07, next read 0x08; DB = Z whenever CS_b = 1.

Source files
------------

// File: rtl/leta_pkg.sv
// Shared sizes, quadrature state type and step classification for the
// LETA trackball quadrature decoder.
package leta_pkg;

  localparam int NCHAN = 4;
  localparam int CNT_W = 8;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_e;

  // Gray order 00->01->11->10->00 is forward; a two-bit change cannot be
  // attributed to a direction and is reported as an error.
  function automatic step_e decode_step(quad_t prev, quad_t cur);
    step_e s;
    s = STEP_NONE;
    case ({prev, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_FWD;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_REV;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s = STEP_ERR;
      default:                                s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/leta_if.sv
// Host-side control/status bundle of the LETA decoder (read select, mode
// controls and per-channel error flags).
interface leta_if #(
  parameter int NCHAN = leta_pkg::NCHAN
);

  logic             CS_b;
  logic [1:0]       AD;
  logic             TEST;
  logic             RESOLN;
  logic [NCHAN-1:0] QERR;

  modport master (output CS_b, AD, TEST, RESOLN, input QERR);
  modport slave  (input CS_b, AD, TEST, RESOLN, output QERR);

endinterface

// File: rtl/quad_channel.sv
// One quadrature channel: input synchronizer, previous-state tracking,
// step decode, position counter and sticky illegal-transition flag.
module quad_channel
  import leta_pkg::quad_t, leta_pkg::step_e, leta_pkg::decode_step,
         leta_pkg::STEP_FWD, leta_pkg::STEP_REV, leta_pkg::STEP_ERR;
#(
  parameter int CNT_W = leta_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             qa,
  input  logic             qb,
  input  logic             test,
  input  logic             resoln,
  input  logic             snap,
  output logic [CNT_W-1:0] count,
  output logic             qerr
);

  logic             a_s1_reg, a_s2_reg;
  logic             b_s1_reg, b_s2_reg;
  quad_t            prev_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             qerr_reg, qerr_next;
  quad_t            cur;
  step_e            step;

  assign cur  = {a_s2_reg, b_s2_reg};
  assign step = decode_step(prev_reg, cur);

  // In x1 mode only the 10<->00 boundary of the cycle counts, so one full
  // Gray cycle moves the position by exactly one.
  always_comb begin
    count_next = count_reg;
    qerr_next  = qerr_reg & ~snap;
    if (test) begin
      count_next = count_reg + 1'b1;
    end else if (valid_reg) begin
      case (step)
        STEP_FWD: if (!resoln || cur == 2'b00) count_next = count_reg + 1'b1;
        STEP_REV: if (!resoln || cur == 2'b10) count_next = count_reg - 1'b1;
        STEP_ERR: qerr_next = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_s1_reg  <= 1'b0;
      a_s2_reg  <= 1'b0;
      b_s1_reg  <= 1'b0;
      b_s2_reg  <= 1'b0;
      prev_reg  <= 2'b00;
      valid_reg <= 1'b0;
      count_reg <= '0;
      qerr_reg  <= 1'b0;
    end else begin
      a_s1_reg  <= qa;
      a_s2_reg  <= a_s1_reg;
      b_s1_reg  <= qb;
      b_s2_reg  <= b_s1_reg;
      prev_reg  <= cur;
      valid_reg <= 1'b1;
      count_reg <= count_next;
      qerr_reg  <= qerr_next;
    end
  end

  assign count = count_reg;
  assign qerr  = qerr_reg;

endmodule

// File: rtl/leta_decoder.sv
// LETA quadrature decoder top: NCHAN channel counters, CS_b-edge snapshot
// into a read latch and the tri-stated DB read port.
module leta_decoder #(
  parameter int NCHAN = leta_pkg::NCHAN,
  parameter int CNT_W = leta_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [NCHAN-1:0] QA,
  input  logic [NCHAN-1:0] QB,
  leta_if.slave            bus,
  output wire  [CNT_W-1:0] DB
);

  logic [CNT_W-1:0] count [NCHAN];
  logic [NCHAN-1:0] qerr;
  logic [NCHAN-1:0] snap_ch;
  logic             cs_s1_reg, cs_s2_reg, cs_s3_reg;
  logic             snap;
  logic [CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] latch_reg;

  // Sync flops reset low so a read already in progress at reset release
  // does not look like a falling edge.
  assign snap = cs_s3_reg & ~cs_s2_reg;

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    assign snap_ch[gi] = snap && (32'(bus.AD) == gi);

    quad_channel #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_b  (rst_b),
      .qa     (QA[gi]),
      .qb     (QB[gi]),
      .test   (bus.TEST),
      .resoln (bus.RESOLN),
      .snap   (snap_ch[gi]),
      .count  (count[gi]),
      .qerr   (qerr[gi])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (32'(bus.AD) == i) rd_data = count[i];
    end
  end

  // The latch samples the registered counter, so a same-cycle count lands
  // in the counter while the latch keeps the pre-update position.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cs_s1_reg <= 1'b0;
      cs_s2_reg <= 1'b0;
      cs_s3_reg <= 1'b0;
      latch_reg <= '0;
    end else begin
      cs_s1_reg <= bus.CS_b;
      cs_s2_reg <= cs_s1_reg;
      cs_s3_reg <= cs_s2_reg;
      if (snap) latch_reg <= rd_data;
    end
  end

  assign bus.QERR = qerr;
  assign DB       = bus.CS_b ? {CNT_W{1'bz}} : latch_reg;

endmodule

// File: tb/tb_leta_decoder.sv
// Directed scoreboard bench for leta_decoder: stimulus queues expected read
// results, a negedge monitor checks DB/QERR when a read latch becomes valid.
module tb_leta_decoder;

  localparam int READ_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [3:0] QA, QB;
  wire  [7:0] db_w;

  leta_if #(.NCHAN(4)) bus ();

  // A released DB bus floats high, so high-Z reads back as 0xFF.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (db_w[gi]);
  end

  leta_decoder #(.NCHAN(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .QA    (QA),
    .QB    (QB),
    .bus   (bus),
    .DB    (db_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] db;
    logic [3:0] qerr;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  int         low_cnt = 0;
  logic [1:0] qs [4];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: the read latch is valid on the READ_LAT-th low cycle of CS_b.
  always @(negedge clk) begin
    if (bus.CS_b === 1'b0 && rst_b === 1'b1) begin
      low_cnt++;
      if (low_cnt == READ_LAT) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read actual=db %02h required=no read", db_w);
        end else begin
          mon_e = sb_q.pop_front();
          $display("read ch%0d db=%02h qerr=%b (expect db=%02h qerr=%b)",
                   mon_e.ch, db_w, bus.QERR, mon_e.db, mon_e.qerr);
          check($sformatf("db_ch%0d", mon_e.ch), db_w, mon_e.db);
          check($sformatf("qerr_after_read_ch%0d", mon_e.ch), bus.QERR, mon_e.qerr);
        end
      end
    end else begin
      low_cnt = 0;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [1:0] fwd_next(logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive_q(int ch);
    QA[ch] = qs[ch][1];
    QB[ch] = qs[ch][0];
  endtask

  task automatic step(int ch, bit fwd);
    qs[ch] = fwd ? fwd_next(qs[ch]) : rev_next(qs[ch]);
    drive_q(ch);
    cyc(4);
  endtask

  task automatic do_reset(bit test_mode);
    cyc(1);
    rst_b = 1'b0;
    QA = '0;
    QB = '0;
    for (int i = 0; i < 4; i++) qs[i] = 2'b00;
    bus.CS_b   = 1'b1;
    bus.AD     = 2'd0;
    bus.RESOLN = 1'b0;
    bus.TEST   = test_mode;
    cyc(2);
    rst_b = 1'b1;
    if (test_mode) begin
      cyc(10);
      bus.TEST = 1'b0;
    end
    cyc(2);
  endtask

  task automatic rd(int ch, logic [7:0] db, logic [3:0] qerr);
    sb_q.push_back('{ch[1:0], db, qerr});
    bus.AD   = ch[1:0];
    bus.CS_b = 1'b0;
    cyc(5);
    bus.CS_b = 1'b1;
    cyc(3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset behaviour of DB and QERR.
    rst_b      = 1'b0;
    QA         = '0;
    QB         = '0;
    bus.CS_b   = 1'b0;
    bus.AD     = 2'd0;
    bus.TEST   = 1'b0;
    bus.RESOLN = 1'b0;
    cyc(2);
    check("db_reset_cs_low", db_w, 8'h00);
    check("qerr_reset", bus.QERR, 4'b0000);
    bus.CS_b = 1'b1;
    #1;
    check("db_reset_cs_high_z", db_w, 8'hFF);

    // 5 forward x4 cycles on ch0.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) step(0, 1'b1);
    rd(0, 8'h14, 4'b0000);
    rd(0, 8'h14, 4'b0000);
    rd(1, 8'h00, 4'b0000);
    rd(2, 8'h00, 4'b0000);
    rd(3, 8'h00, 4'b0000);

    // x1 resolution: 3 reverse cycles on ch2.
    do_reset(1'b0);
    bus.RESOLN = 1'b1;
    for (int i = 0; i < 12; i++) step(2, 1'b0);
    step(2, 1'b1);
    rd(2, 8'hFD, 4'b0000);
    rd(0, 8'h00, 4'b0000);

    // Wrap on ch1 in both directions.
    do_reset(1'b0);
    step(1, 1'b0);
    rd(1, 8'hFF, 4'b0000);
    step(1, 1'b1);
    rd(1, 8'h00, 4'b0000);
    step(1, 1'b0);
    rd(1, 8'hFF, 4'b0000);

    // Illegal jump on ch3; only a read of ch3 clears its flag.
    do_reset(1'b0);
    qs[3] = 2'b11;
    drive_q(3);
    cyc(4);
    check("qerr3_set", bus.QERR, 4'b1000);
    rd(3, 8'h00, 4'b0000);
    qs[3] = 2'b00;
    drive_q(3);
    cyc(4);
    check("qerr3_set_again", bus.QERR, 4'b1000);
    rd(0, 8'h00, 4'b1000);
    rd(3, 8'h00, 4'b0000);

    // Count coinciding with the snapshot edge on ch0 at 0x07.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) step(0, 1'b1);
    sb_q.push_back('{2'd0, 8'h07, 4'b0000});
    bus.AD = 2'd0;
    qs[0]  = fwd_next(qs[0]);
    drive_q(0);
    bus.CS_b = 1'b0;
    cyc(5);
    bus.CS_b = 1'b1;
    cyc(3);
    rd(0, 8'h08, 4'b0000);
    check("db_idle_z", db_w, 8'hFF);

    // TEST mode for 10 clocks from reset.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) rd(i, 8'h0A, 4'b0000);

    cyc(2);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
